// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver (8N1 default, LSB first) with framing/overrun flags.
// Define UART_RX_PARITY_EN to add one even-parity bit between data and stop.
`timescale 1ns/1ps
module uart_rx #(
    parameter int DATA_BITS = 8,
    parameter int OVS       = 16
) (
    input  logic                 clk_50m,
    input  logic                 rst_n,
    input  logic                 clk_en,
    input  logic                 rx,
    input  logic                 rdy_clr,
    output logic [DATA_BITS-1:0] data,
    output logic                 rdy,
    output logic                 frm_err,
    output logic                 overrun,
    output logic                 parity_err
);
    localparam int SW = $clog2(OVS);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [SW-1:0] HALF_M1  = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] FULL_M1  = SW'(OVS - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [SW-1:0]        r_sample, w_sample_nxt;
    logic [BW-1:0]        r_bitcnt, w_bitcnt_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic                 r_rx_meta, r_rx_s;
    logic                 w_good, w_bad;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_rdy, r_frm_err, r_overrun;
`ifdef UART_RX_PARITY_EN
    logic                 r_par, w_par_nxt, r_parity_err;
`endif

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_sample <= '0;
            r_bitcnt <= '0;
            r_shift  <= '0;
`ifdef UART_RX_PARITY_EN
            r_par    <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_sample <= w_sample_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_shift  <= w_shift_nxt;
`ifdef UART_RX_PARITY_EN
            r_par    <= w_par_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_sample_nxt = r_sample;
        w_bitcnt_nxt = r_bitcnt;
        w_shift_nxt  = r_shift;
`ifdef UART_RX_PARITY_EN
        w_par_nxt    = r_par;
`endif
        w_good       = 1'b0;
        w_bad        = 1'b0;
        if (clk_en) begin
            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s) begin
                        w_state_nxt  = S_START;
                        w_sample_nxt = '0;
                    end
                end
                S_START: begin
                    // Re-check the line at mid start bit; a high here was a glitch.
                    if (r_sample == HALF_M1) begin
                        w_sample_nxt = '0;
                        w_bitcnt_nxt = '0;
                        w_state_nxt  = r_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        w_sample_nxt = r_sample + SW'(1);
                    end
                end
                S_DATA: begin
                    if (r_sample == FULL_M1) begin
                        w_sample_nxt = '0;
                        w_shift_nxt  = {r_rx_s, r_shift[DATA_BITS-1:1]};
                        w_bitcnt_nxt = r_bitcnt + BW'(1);
                        if (r_bitcnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            w_state_nxt = S_PARITY;
`else
                            w_state_nxt = S_STOP;
`endif
                        end
                    end else begin
                        w_sample_nxt = r_sample + SW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (r_sample == FULL_M1) begin
                        w_sample_nxt = '0;
                        w_par_nxt    = r_rx_s;
                        w_state_nxt  = S_STOP;
                    end else begin
                        w_sample_nxt = r_sample + SW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (r_sample == FULL_M1) begin
                        w_sample_nxt = '0;
                        w_good       = r_rx_s;
                        w_bad        = !r_rx_s;
                        w_state_nxt  = r_rx_s ? S_IDLE : S_BREAK;
                    end else begin
                        w_sample_nxt = r_sample + SW'(1);
                    end
                end
                S_BREAK: begin
                    if (r_rx_s) w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // A good frame landing on the same edge as rdy_clr wins: the old word was acknowledged.
    always_ff @(posedge clk_50m) begin
        if (!rst_n) begin
            r_data    <= '0;
            r_rdy     <= 1'b0;
            r_frm_err <= 1'b0;
            r_overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else if (w_good) begin
            r_data    <= r_shift;
            r_rdy     <= 1'b1;
            r_frm_err <= 1'b0;
            r_overrun <= r_rdy && !rdy_clr;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= ^{r_shift, r_par};
`endif
        end else begin
            if (w_bad) r_frm_err <= 1'b1;
            if (rdy_clr) begin
                r_rdy     <= 1'b0;
                r_overrun <= 1'b0;
            end
        end
    end

    assign data    = r_data;
    assign rdy     = r_rdy;
    assign frm_err = r_frm_err;
    assign overrun = r_overrun;
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table of frames, hand-written corner sequences, then random frames
// against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int DB  = 8;
    localparam int OVS = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit HAS_PAR = 1'b1;
`else
    localparam bit HAS_PAR = 1'b0;
`endif

    logic          clk_50m = 1'b0;
    logic          rst_n   = 1'b0;
    logic          clk_en  = 1'b0;
    logic          rx      = 1'b1;
    logic          rdy_clr = 1'b0;
    logic [DB-1:0] data;
    logic          rdy, frm_err, overrun, parity_err;

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;

    logic [7:0] m_data;
    logic       m_rdy, m_frm, m_ovr, m_par;

    uart_rx #(.DATA_BITS(DB), .OVS(OVS)) dut (
        .clk_50m   (clk_50m),
        .rst_n     (rst_n),
        .clk_en    (clk_en),
        .rx        (rx),
        .rdy_clr   (rdy_clr),
        .data      (data),
        .rdy       (rdy),
        .frm_err   (frm_err),
        .overrun   (overrun),
        .parity_err(parity_err)
    );

    always #5 clk_50m = ~clk_50m;

    always @(negedge clk_50m) begin
        en_cnt = (en_cnt + 1) % 4;
        clk_en = (en_cnt == 0);
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_50m);
            while (!clk_en) @(posedge clk_50m);
        end
        #1;
    endtask

    task automatic send_head(input logic [7:0] d, input logic par);
        rx = 1'b0;
        tick(OVS);
        for (int i = 0; i < DB; i++) begin
            rx = d[i];
            tick(OVS);
        end
        if (HAS_PAR) begin
            rx = par;
            tick(OVS);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
        send_head(d, par);
        rx = stop;
        tick(OVS);
        rx = 1'b1;
    endtask

    task automatic model_frame(input logic [7:0] d, input logic stop, input logic par);
        if (stop) begin
            m_ovr  = m_rdy;
            m_data = d;
            m_rdy  = 1'b1;
            m_frm  = 1'b0;
            m_par  = HAS_PAR ? ((^d) ^ par) : 1'b0;
        end else begin
            m_frm = 1'b1;
        end
    endtask

    task automatic model_reset();
        m_data = '0; m_rdy = 0; m_frm = 0; m_ovr = 0; m_par = 0;
    endtask

    task automatic do_clr();
        @(negedge clk_50m) rdy_clr = 1'b1;
        @(negedge clk_50m) rdy_clr = 1'b0;
        #1;
        m_rdy = 1'b0;
        m_ovr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_50m) rst_n = 1'b0;
        @(negedge clk_50m) rst_n = 1'b1;
        rx = 1'b1;
        #1;
        model_reset();
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".data"},       32'(data),       32'(m_data));
        chk({tag, ".rdy"},        32'(rdy),        32'(m_rdy));
        chk({tag, ".frm_err"},    32'(frm_err),    32'(m_frm));
        chk({tag, ".overrun"},    32'(overrun),    32'(m_ovr));
        chk({tag, ".parity_err"}, 32'(parity_err), 32'(m_par));
    endtask

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       clr;
        logic [7:0] e_data;
        logic       e_rdy;
        logic       e_frm;
        logic       e_ovr;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [7:0] d;
        logic       stop, par;
        tbl[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{8'h22, 1'b1, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{8'h3C, 1'b0, 1'b0, 8'h22, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{8'h81, 1'b1, 1'b0, 8'h81, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{8'h00, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1};
        tbl[7] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};

        model_reset();
        repeat (4) @(negedge clk_50m);
        check_all("reset");
        rst_n = 1'b1;
        tick(4);

        foreach (tbl[i]) begin
            par = ^tbl[i].d;
            send_frame(tbl[i].d, tbl[i].stop, par);
            if (!tbl[i].stop) begin
                rx = 1'b1;
                tick(2);
            end
            model_frame(tbl[i].d, tbl[i].stop, par);
            chk($sformatf("tbl%0d.data", i),    32'(data),    32'(tbl[i].e_data));
            chk($sformatf("tbl%0d.rdy", i),     32'(rdy),     32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d.frm_err", i), 32'(frm_err), 32'(tbl[i].e_frm));
            chk($sformatf("tbl%0d.overrun", i), 32'(overrun), 32'(tbl[i].e_ovr));
            chk($sformatf("tbl%0d.parity", i),  32'(parity_err), 32'(0));
            if (tbl[i].clr) begin
                do_clr();
                chk($sformatf("tbl%0d.clr_rdy", i), 32'(rdy),     32'(0));
                chk($sformatf("tbl%0d.clr_ovr", i), 32'(overrun), 32'(0));
                chk($sformatf("tbl%0d.clr_frm", i), 32'(frm_err), 32'(m_frm));
            end
        end

        // Short low pulse on the line must not produce a frame.
        do_clr();
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        tick(20);
        check_all("glitch");
        send_frame(8'h5A, 1'b1, ^8'h5A);
        model_frame(8'h5A, 1'b1, ^8'h5A);
        check_all("after_glitch");

        // Bad stop with the line held low: no retrigger until it returns high.
        do_reset();
        check_all("reset2");
        send_head(8'h3C, ^8'h3C);
        rx = 1'b0;
        tick(40);
        rx = 1'b1;
        tick(4);
        model_frame(8'h3C, 1'b0, 1'b0);
        check_all("break");
        send_frame(8'h81, 1'b1, ^8'h81);
        model_frame(8'h81, 1'b1, ^8'h81);
        check_all("after_break");

        // Reset during data bit 3 abandons the frame.
        rx = 1'b0;
        tick(OVS);
        for (int i = 0; i < 3; i++) begin
            rx = 1'b1;
            tick(OVS);
        end
        rx = 1'b0;
        tick(OVS / 2);
        do_reset();
        check_all("mid_reset");
        tick(20);
        send_frame(8'h5A, 1'b1, ^8'h5A);
        model_frame(8'h5A, 1'b1, ^8'h5A);
        check_all("after_reset");

`ifdef UART_RX_PARITY_EN
        do_clr();
        send_frame(8'h07, 1'b1, 1'b0);
        model_frame(8'h07, 1'b1, 1'b0);
        check_all("par_bad");
        do_clr();
        chk("par_bad.kept_after_clr", 32'(parity_err), 32'(1));
        send_frame(8'h07, 1'b1, 1'b1);
        model_frame(8'h07, 1'b1, 1'b1);
        check_all("par_good");
`endif

        for (int n = 0; n < 30; n++) begin
            d    = 8'($urandom);
            stop = ($urandom % 6) != 0;
            par  = 1'($urandom);
            if ($urandom % 2 == 0) do_clr();
            send_frame(d, stop, par);
            model_frame(d, stop, par);
            if (!stop) begin
                rx = 1'b1;
                tick(2);
            end
            tick($urandom % 3);
            check_all($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
